// File: rtl/pagerank_write_packer_if.sv
// AXI write-channel bundle (aw/w/b) of the PageRank memory port.
// The master modport is the packer side; slave is the memory side.
interface pagerank_write_packer_if #(
  parameter int unsigned FULL_WIDTH = 512
);
  logic [15:0]             awid_m;
  logic [63:0]             awaddr_m;
  logic [7:0]              awlen_m;
  logic [2:0]              awsize_m;
  logic                    awvalid_m;
  logic                    awready_m;
  logic [15:0]             wid_m;
  logic [FULL_WIDTH-1:0]   wdata_m;
  logic [FULL_WIDTH/8-1:0] wstrb_m;
  logic                    wlast_m;
  logic                    wvalid_m;
  logic                    wready_m;
  logic [15:0]             bid_m;
  logic [1:0]              bresp_m;
  logic                    bvalid_m;
  logic                    bready_m;

  modport master (
    output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
    input  awready_m,
    output wid_m, wdata_m, wstrb_m, wlast_m, wvalid_m,
    input  wready_m,
    input  bid_m, bresp_m, bvalid_m,
    output bready_m
  );

  modport slave (
    input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
    output awready_m,
    input  wid_m, wdata_m, wstrb_m, wlast_m, wvalid_m,
    output wready_m,
    output bid_m, bresp_m, bvalid_m,
    input  bready_m
  );
endinterface

// File: rtl/pagerank_write_packer.sv
// Packs a stream of PageRank elements into full lines and writes each line
// as a single-beat AXI burst, one write outstanding at a time.
module pagerank_write_packer #(
  parameter int unsigned FULL_WIDTH = 512,
  parameter int unsigned WIDTH      = 64,
  parameter logic [15:0] AXI_ID     = 16'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [63:0]          base_addr,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  pagerank_write_packer_if.master axi,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          lines_written,
  output logic                 err
);
  localparam int unsigned LANES      = FULL_WIDTH / WIDTH;
  localparam int unsigned LW         = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LANE_BYTES = WIDTH / 8;
  localparam int unsigned LINE_BYTES = FULL_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, RESP, DONE} state_t;

  state_t                  state;
  logic [63:0]             addr;
  logic [LW-1:0]           lane;
  logic                    last_line;
  logic                    aw_valid;
  logic                    w_valid;
  logic                    b_ready;
  logic [FULL_WIDTH-1:0]   wdata;
  logic [FULL_WIDTH/8-1:0] wstrb;
  logic                    aw_ok;
  logic                    w_ok;
  logic                    unused_inputs;

  // A channel counts as finished once its valid has dropped or is handshaking now.
  assign aw_ok = !aw_valid || axi.awready_m;
  assign w_ok  = !w_valid  || axi.wready_m;

  assign unused_inputs = ^{axi.bid_m, base_addr[$clog2(LINE_BYTES)-1:0]};

  assign axi.awid_m    = AXI_ID;
  assign axi.awaddr_m  = addr;
  assign axi.awlen_m   = 8'd0;
  assign axi.awsize_m  = 3'b110;
  assign axi.awvalid_m = aw_valid;
  assign axi.wid_m     = AXI_ID;
  assign axi.wdata_m   = wdata;
  assign axi.wstrb_m   = wstrb;
  assign axi.wlast_m   = w_valid;
  assign axi.wvalid_m  = w_valid;
  assign axi.bready_m  = b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      lane          <= '0;
      last_line     <= 1'b0;
      in_ready      <= 1'b0;
      aw_valid      <= 1'b0;
      w_valid       <= 1'b0;
      b_ready       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      lines_written <= '0;
      wdata         <= '0;
      wstrb         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr          <= base_addr & ~64'(LINE_BYTES - 1);
            lane          <= '0;
            lines_written <= '0;
            err           <= 1'b0;
            busy          <= 1'b1;
            in_ready      <= 1'b1;
            state         <= FILL;
          end
        end
        FILL: begin
          if (in_valid && in_ready) begin
            wdata[WIDTH*lane +: WIDTH]           <= in_data;
            wstrb[LANE_BYTES*lane +: LANE_BYTES] <= '1;
            lane <= lane + 1'b1;
            if (lane == LW'(LANES - 1) || in_last) begin
              last_line <= in_last;
              in_ready  <= 1'b0;
              aw_valid  <= 1'b1;
              w_valid   <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (aw_valid && axi.awready_m) aw_valid <= 1'b0;
          if (w_valid && axi.wready_m)   w_valid  <= 1'b0;
          if (aw_ok && w_ok) begin
            b_ready <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (axi.bvalid_m) begin
            lines_written <= lines_written + 32'd1;
            if (axi.bresp_m != 2'b00) err <= 1'b1;
            addr    <= addr + 64'(LINE_BYTES);
            wdata   <= '0;
            wstrb   <= '0;
            lane    <= '0;
            b_ready <= 1'b0;
            if (last_line) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= FILL;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pagerank_write_packer.md
Name: pagerank_write_packer

Overview:
Write-side counterpart to the vertex read buffer. It accepts a stream of 64-bit PageRank results and packs them into 512-bit lines. Each line goes out as a single-beat AXI write on the aw/w/b channels of the PageRank memory port. It sits between the PageRank compute logic and the memory master, and targets the write_addr0/write_addr1 regions.

Parameters:
FULL_WIDTH, 512, AXI write data width in bits (one line).
WIDTH, 64, element width in bits; FULL_WIDTH/WIDTH = LANES (8).
AXI_ID, 0, constant value driven on awid_m and wid_m.

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches base_addr and begins a run (honoured in IDLE only)
base_addr  in  64  byte address of first line; low 6 bits are ignored (treated as 0)
in_valid  in  1  element valid
in_data  in  WIDTH  element value
in_last  in  1  final element of the run (qualified by in_valid)
in_ready  out  1  element accepted when in_valid & in_ready
awid_m  out  16  AXI_ID
awaddr_m  out  64  line address
awlen_m  out  8  always 0
awsize_m  out  3  always 3'b110
awvalid_m  out  1  address valid
awready_m  in  1  address accepted
wid_m  out  16  AXI_ID
wdata_m  out  FULL_WIDTH  packed line
wstrb_m  out  FULL_WIDTH/8  byte strobes
wlast_m  out  1  equals wvalid_m
wvalid_m  out  1  data valid
wready_m  in  1  data accepted
bid_m  in  16  ignored
bresp_m  in  2  write response
bvalid_m  in  1  response valid
bready_m  out  1  response accept
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the run completes
lines_written  out  32  count of B responses received this run
err  out  1  sticky; set on any bresp_m != 0, cleared by start

Behaviour:
- States: IDLE, FILL, ISSUE, RESP, DONE.
- Reset: state IDLE; awvalid_m, wvalid_m, bready_m, in_ready, busy, done, err all 0; lines_written 0; wdata_m 0; wstrb_m 0.
- IDLE: on start, latch addr = {base_addr[63:6], 6'b0}, lane = 0, lines_written = 0, err = 0, then go to FILL. A start pulse outside IDLE is ignored.
- FILL: in_ready = 1.
  - Each accepted element writes in_data to wdata_m[WIDTH*lane +: WIDTH] and sets wstrb_m[8*lane +: 8] to all ones; lane increments.
  - Accepting lane LANES-1, or any accept with in_last, moves to ISSUE on the next cycle. in_last is recorded in a last_line flag.
  - Unfilled lanes keep data 0 and strobe 0 (partial-line flush).
- ISSUE: in_ready = 0.
  - awvalid_m and wvalid_m both assert on the first ISSUE cycle.
  - Each channel drops its valid the cycle after its own handshake; the two channels are handshaken independently, in either order or the same cycle.
  - awaddr_m, wdata_m and wstrb_m hold stable while their valid is high.
  - Once both handshakes are done, go to RESP.
- RESP: bready_m = 1.
  - On bvalid_m: lines_written increments; err is set if bresp_m != 0; addr += 64.
  - Then clear wdata_m and wstrb_m and set lane = 0.
  - Next state is DONE if last_line, otherwise FILL.
- DONE: done = 1 for exactly one cycle, then IDLE. busy is low from IDLE onward.
- Minimum latency per full line: 8 FILL cycles, then 1 ISSUE cycle with immediate ready, then 1 RESP cycle with immediate bvalid.
- Only one write is outstanding at a time; no new element is accepted until the B response of the previous line arrives.
- in_last on lane LANES-1 issues exactly one full line; no empty line follows.
- addr wraps modulo 2^64 with no error.
- rst mid-operation (any state) aborts the run the next cycle: all valids drop and any pending AW/W/B handshake is abandoned.

Test Plan:
- Full line: start with base_addr=0x1000, feed 8 elements 1..8 with in_last on the 8th → one AW at 0x1000, wdata lane k = k+1, wstrb all ones, then done pulse; lines_written=1.
- Partial flush: feed 3 elements with in_last → wdata lanes 3..7 = 0, wstrb = 64'h0000_0000_00FF_FFFF, awaddr = base.
- Multi-line with misaligned base: base_addr=0x2013, feed 20 elements → lines at 0x2000, 0x2040, 0x2080; third wstrb = 64'h0000_0000_FFFF_FFFF; lines_written=3.
- Handshake skew: awready delayed 3 cycles while wready is immediate (and the reverse order) → each valid deasserts the cycle after its own handshake; RESP is entered only after both; in_ready stays 0 until bvalid.
- Error and ignored start: bresp=2'b10 on line 1 → err=1 and stays set through done; a start pulse during FILL is ignored; the next start clears err.
- Reset mid-ISSUE: assert rst while awvalid=1 → next cycle awvalid=wvalid=bready=in_ready=busy=0, state IDLE; a fresh start runs correctly.
